// File: rtl/ripple_adder_4b.sv
// ripple_adder_4b: registered ripple-carry adder.
//   Sums a + b + cin through a chain of WIDTH full-adder cells and registers
//   the sum, every per-stage carry and the final carry-out. Latency is 1 cycle.
//
// Parameters
//   WIDTH      operand/sum width (2..32, default 4)
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears all outputs, wins over in_valid
//   in_valid   qualifies a, b, cin this cycle
//   a, b       WIDTH-bit operands
//   cin        carry into bit 0
//   sum        registered a + b + cin mod 2^WIDTH (held while in_valid=0)
//   carry      registered per-stage carries; carry[i] = carry out of bit i
//   cout       registered carry out of the MSB (== carry[WIDTH-1])
//   overflow   registered signed overflow, present only when
//              RIPPLE_ADDER_OVERFLOW_EN is defined
//   out_valid  registered in_valid

module ripple_adder_4b_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end
endmodule

module ripple_adder_4b #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             cout,
`ifdef RIPPLE_ADDER_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the final carry-out.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    ripple_adder_4b_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  logic [WIDTH-1:0] sum_d, sum_q;
  logic [WIDTH-1:0] carry_d, carry_q;
  logic             out_valid_d, out_valid_q;

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    // Mux on in_valid keeps unknown operands out of the held registers.
    if (in_valid) begin
      sum_d   = s;
      carry_d = c[WIDTH:1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic overflow_d, overflow_q;

  always_comb begin
    overflow_d = overflow_q;
    if (in_valid) begin
      overflow_d = c[WIDTH] ^ c[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`endif

  assign sum       = sum_q;
  assign carry     = carry_q;
  // The MSB carry register doubles as the carry-out flop, so the two can never disagree.
  assign cout      = carry_q[WIDTH-1];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ripple_adder_4b.sv
// Self-checking bench for ripple_adder_4b: a 4-bit instance (directed table,
// hold/reset sequences, exhaustive sweep) and an 8-bit instance (random sweep).
module tb_ripple_adder_4b;

  typedef struct {
    logic [31:0] sum;
    logic [31:0] carry;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic [3:0] carry;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       iv4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] sum4, carry4;
  logic       cout4, ov4;

  logic       iv8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] sum8, carry8;
  logic       cout8, ov8;

`ifdef RIPPLE_ADDER_OVERFLOW_EN
  logic ovf4, ovf8;
`endif

  int checks = 0;
  int failures = 0;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8, last8;

  always #5 clk = ~clk;

  ripple_adder_4b #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .cin(cin4),
    .sum(sum4), .carry(carry4), .cout(cout4),
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    .overflow(ovf4),
`endif
    .out_valid(ov4)
  );

  ripple_adder_4b #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .carry(carry8), .cout(cout8),
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    .overflow(ovf8),
`endif
    .out_valid(ov8)
  );

  // Arithmetic reference: each stage carry is taken from a masked partial sum.
  function automatic exp_t model(input int unsigned w, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci);
    exp_t r;
    logic [32:0] mask, part;
    r.carry = '0;
    for (int unsigned i = 0; i < w; i++) begin
      mask = (33'd1 << (i + 1)) - 33'd1;
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, ci};
      r.carry[i] = part[i+1];
    end
    mask   = (33'd1 << w) - 33'd1;
    part   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, ci};
    r.sum  = part[31:0] & mask[31:0];
    r.cout = part[w];
    r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard pops: one expected record per out_valid cycle.
  always @(negedge clk) begin
    if (ov4) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb4_unexpected actual=out_valid required=empty");
      end else begin
        e4 = q4.pop_front();
        check("sb4_sum", {28'd0, sum4}, e4.sum);
        check("sb4_carry", {28'd0, carry4}, e4.carry);
        check("sb4_cout", {31'd0, cout4}, {31'd0, e4.cout});
`ifdef RIPPLE_ADDER_OVERFLOW_EN
        check("sb4_ovf", {31'd0, ovf4}, {31'd0, e4.ovf});
`endif
      end
    end
    if (ov8) begin
      if (q8.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb8_unexpected actual=out_valid required=empty");
      end else begin
        e8 = q8.pop_front();
        check("sb8_sum", {24'd0, sum8}, e8.sum);
        check("sb8_carry", {24'd0, carry8}, e8.carry);
        check("sb8_cout", {31'd0, cout8}, {31'd0, e8.cout});
`ifdef RIPPLE_ADDER_OVERFLOW_EN
        check("sb8_ovf", {31'd0, ovf8}, {31'd0, e8.ovf});
`endif
      end
    end
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{4'b0001, 4'b0110, 1'b1, 4'b1000, 4'b0111, 1'b0, 1'b1};
    vecs[1] = '{4'b0101, 4'b1110, 1'b0, 4'b0011, 4'b1100, 1'b1, 1'b0};
    vecs[2] = '{4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0};
    vecs[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0};
    vecs[4] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b0111, 1'b0, 1'b1};
    vecs[5] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b1, 1'b1};

    // Reset held for two edges with a valid operand that must be ignored.
    rst = 1'b1; iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; cin4 = 1'b1;
    step(); step();
    check("rst_sum", {28'd0, sum4}, 32'd0);
    check("rst_carry", {28'd0, carry4}, 32'd0);
    check("rst_cout", {31'd0, cout4}, 32'd0);
    check("rst_out_valid", {31'd0, ov4}, 32'd0);
    check("rst8_out_valid", {31'd0, ov8}, 32'd0);
`ifdef RIPPLE_ADDER_OVERFLOW_EN
    check("rst_ovf", {31'd0, ovf4}, 32'd0);
`endif
    rst = 1'b0; iv4 = 1'b0;
    step();

    // Directed table, back to back.
    for (int i = 0; i < 6; i++) begin
      iv4 = 1'b1; a4 = vecs[i].a; b4 = vecs[i].b; cin4 = vecs[i].cin;
      q4.push_back('{{28'd0, vecs[i].sum}, {28'd0, vecs[i].carry}, vecs[i].cout, vecs[i].ovf});
      step();
    end
    iv4 = 1'b0;
    step(); step();

    // Hold: unknown operands while in_valid=0 must not disturb the outputs.
    iv4 = 1'b1; a4 = 4'b0011; b4 = 4'b0100; cin4 = 1'b0;
    q4.push_back(model(4, 32'h3, 32'h4, 1'b0));
    step();
    iv4 = 1'b0; a4 = 'x; b4 = 'x; cin4 = 1'bx;
    step();
    check("hold_sum", {28'd0, sum4}, 32'h7);
    check("hold_out_valid", {31'd0, ov4}, 32'd0);
    step();
    check("hold2_sum", {28'd0, sum4}, 32'h7);

    // Reset mid-stream alongside a valid operand: the operand is dropped.
    iv4 = 1'b1; a4 = 4'b0010; b4 = 4'b0011; cin4 = 1'b0;
    q4.push_back(model(4, 32'h2, 32'h3, 1'b0));
    step();
    rst = 1'b1; a4 = 4'b0001; b4 = 4'b0110; cin4 = 1'b1;
    step();
    check("midrst_sum", {28'd0, sum4}, 32'd0);
    check("midrst_carry", {28'd0, carry4}, 32'd0);
    check("midrst_out_valid", {31'd0, ov4}, 32'd0);
    rst = 1'b0; iv4 = 1'b0;
    step();
    check("dropped_out_valid", {31'd0, ov4}, 32'd0);
    check("dropped_sum", {28'd0, sum4}, 32'd0);

    // Exhaustive 4-bit sweep, back to back.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int z = 0; z < 2; z++) begin
          iv4 = 1'b1; a4 = 4'(x); b4 = 4'(y); cin4 = z[0];
          q4.push_back(model(4, 32'(x), 32'(y), z[0]));
          step();
        end
    iv4 = 1'b0;
    step(); step();

    // Random 8-bit sweep with occasional idle cycles.
    last8 = '{32'd0, 32'd0, 1'b0, 1'b0};
    for (int k = 0; k < 300; k++) begin
      iv8 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (iv8) begin
        last8 = model(8, {24'd0, a8}, {24'd0, b8}, cin8);
        q8.push_back(last8);
      end
      step();
    end
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    step(); step();
    check("hold8_sum", {24'd0, sum8}, last8.sum);
    check("hold8_carry", {24'd0, carry8}, last8.carry);

    check("sb4_drained", 32'(q4.size()), 32'd0);
    check("sb8_drained", 32'(q8.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
